// File: rtl/timer_pkg.sv
// Shared register map and control-register bit positions for the timer array.
package timer_pkg;

    localparam logic [1:0] REG_TL  = 2'd0;
    localparam logic [1:0] REG_TH  = 2'd1;
    localparam logic [1:0] REG_CON = 2'd2;
    localparam logic [1:0] REG_PSC = 2'd3;

    localparam int CON_EN      = 0;
    localparam int CON_IE      = 1;
    localparam int CON_STAT    = 2;
    localparam int CON_ONESHOT = 3;
    localparam int CON_W       = 4;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: reload/count/control/prescale registers, prescaler and
// auto-reload counter with sticky overflow status.
module timer_channel
    import timer_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int PSC_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_wr_tl,
    input  logic               i_wr_th,
    input  logic               i_wr_con,
    input  logic               i_wr_psc,
    input  logic [WIDTH-1:0]   i_wdata,
    output logic [WIDTH-1:0]   o_tl,
    output logic [WIDTH-1:0]   o_th,
    output logic [CON_W-1:0]   o_con,
    output logic [PSC_W-1:0]   o_psc,
    output logic               o_ovf
);

    logic [WIDTH-1:0] r_tl;
    logic [WIDTH-1:0] r_th;
    logic [PSC_W-1:0] r_psc;
    logic [PSC_W-1:0] r_pc;
    logic             r_en;
    logic             r_ie;
    logic             r_stat;
    logic             r_oneshot;
    logic             r_ovf;

    logic w_tick;
    logic w_ovf;

    assign w_tick = r_en && (r_pc == r_psc);
    // A TH write on the same edge discards the tick, so no overflow either.
    assign w_ovf  = w_tick && (&r_th) && !i_wr_th;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tl      <= '0;
            r_th      <= '0;
            r_psc     <= '0;
            r_pc      <= '0;
            r_en      <= 1'b0;
            r_ie      <= 1'b0;
            r_stat    <= 1'b0;
            r_oneshot <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            r_ovf <= w_ovf;

            if (i_wr_tl)
                r_tl <= i_wdata;

            if (i_wr_psc)
                r_psc <= i_wdata[PSC_W-1:0];

            if (i_wr_psc || !r_en || w_tick)
                r_pc <= '0;
            else
                r_pc <= r_pc + 1'b1;

            // Reload reads r_tl before this edge's TL write lands.
            if (i_wr_th)
                r_th <= i_wdata;
            else if (w_tick)
                r_th <= (&r_th) ? r_tl : r_th + 1'b1;

            if (i_wr_con) begin
                r_en      <= i_wdata[CON_EN];
                r_ie      <= i_wdata[CON_IE];
                r_oneshot <= i_wdata[CON_ONESHOT];
            end else if (w_ovf && r_oneshot) begin
                r_en <= 1'b0;
            end

            // Overflow set takes priority over write-1-to-clear.
            if (w_ovf)
                r_stat <= 1'b1;
            else if (i_wr_con && i_wdata[CON_STAT])
                r_stat <= 1'b0;
        end
    end

    assign o_tl  = r_tl;
    assign o_th  = r_th;
    assign o_psc = r_psc;
    assign o_ovf = r_ovf;

    always_comb begin
        o_con              = '0;
        o_con[CON_EN]      = r_en;
        o_con[CON_IE]      = r_ie;
        o_con[CON_STAT]    = r_stat;
        o_con[CON_ONESHOT] = r_oneshot;
    end

endmodule

// File: rtl/timer_array.sv
// Multi-channel timer: address decode, combinational read mux and registered
// interrupt OR over all channels.
module timer_array
    import timer_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int N_CH   = 2,
    parameter int PSC_W  = 8,
    parameter int ADDR_W = $clog2(N_CH) + 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  wdata,
    output logic [WIDTH-1:0]  rdata,
    output logic              irq,
    output logic [N_CH-1:0]   ovf
);

    localparam int CH_W = (ADDR_W > 2) ? ADDR_W - 2 : 1;

    logic [CH_W-1:0]  w_ch;
    logic [1:0]       w_reg;
    logic [WIDTH-1:0] w_tl  [N_CH];
    logic [WIDTH-1:0] w_th  [N_CH];
    logic [CON_W-1:0] w_con [N_CH];
    logic [PSC_W-1:0] w_psc [N_CH];
    logic [N_CH-1:0]  w_sel;
    logic [N_CH-1:0]  w_irq_vec;
    logic             r_irq;

    assign w_ch  = CH_W'(addr >> 2);
    assign w_reg = addr[1:0];

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            assign w_sel[gi]     = wr_en && (w_ch == CH_W'(gi));
            assign w_irq_vec[gi] = w_con[gi][CON_STAT] & w_con[gi][CON_IE];

            timer_channel #(
                .WIDTH (WIDTH),
                .PSC_W (PSC_W)
            ) u_ch (
                .clk      (clk),
                .rst_n    (rst_n),
                .i_wr_tl  (w_sel[gi] && (w_reg == REG_TL)),
                .i_wr_th  (w_sel[gi] && (w_reg == REG_TH)),
                .i_wr_con (w_sel[gi] && (w_reg == REG_CON)),
                .i_wr_psc (w_sel[gi] && (w_reg == REG_PSC)),
                .i_wdata  (wdata),
                .o_tl     (w_tl[gi]),
                .o_th     (w_th[gi]),
                .o_con    (w_con[gi]),
                .o_psc    (w_psc[gi]),
                .o_ovf    (ovf[gi])
            );
        end
    endgenerate

    // Channel indices with no instance fall through to zero.
    always_comb begin
        rdata = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (w_ch == CH_W'(i)) begin
                case (w_reg)
                    REG_TL:  rdata = w_tl[i];
                    REG_TH:  rdata = w_th[i];
                    REG_CON: rdata = WIDTH'(w_con[i]);
                    default: rdata = WIDTH'(w_psc[i]);
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_irq <= 1'b0;
        else
            r_irq <= |w_irq_vec;
    end

    assign irq = r_irq;

endmodule

// File: tb/tb_timer_array.sv
// Directed self-checking bench for timer_array with three channels.
module tb_timer_array;

    localparam int WIDTH  = 32;
    localparam int N_CH   = 3;
    localparam int ADDR_W = 4;

    logic              clk;
    logic              rst_n;
    logic              wr_en;
    logic [ADDR_W-1:0] addr;
    logic [WIDTH-1:0]  wdata;
    logic [WIDTH-1:0]  rdata;
    logic              irq;
    logic [N_CH-1:0]   ovf;

    int n_cmp = 0;
    int n_err = 0;

    timer_array #(
        .WIDTH (WIDTH),
        .N_CH  (N_CH),
        .PSC_W (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .wr_en (wr_en),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .irq   (irq),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d);
        wr_en = 1'b1;
        addr  = a;
        wdata = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic [ADDR_W-1:0] a, output logic [WIDTH-1:0] d);
        addr = a;
        #1;
        d = rdata;
    endtask

    task automatic test_reset();
        logic [WIDTH-1:0] v;
        for (int a = 0; a < 4; a++) begin
            rd(ADDR_W'(a), v);
            n_cmp++;
            if (v !== '0) begin
                n_err++;
                $display("FAIL reset_reg%0d got %h exp 0", a, v);
            end
        end
        n_cmp++;
        if (irq !== 1'b0 || ovf !== '0) begin
            n_err++;
            $display("FAIL reset_outs got irq=%b ovf=%b exp 0/000", irq, ovf);
        end
        wr(4'd1, 32'd0);
        wr(4'd2, 32'h3);
        repeat (5) step();
        rd(4'd1, v);
        n_cmp++;
        if (v !== 32'd5) begin
            n_err++;
            $display("FAIL midcount_th got %h exp 5", v);
        end
        #2 rst_n = 1'b0;
        #1;
        rd(4'd1, v);
        n_cmp++;
        if (v !== 32'd0) begin
            n_err++;
            $display("FAIL async_rst_th got %h exp 0", v);
        end
        rd(4'd2, v);
        n_cmp++;
        if (v !== 32'd0 || irq !== 1'b0) begin
            n_err++;
            $display("FAIL async_rst_con got con=%h irq=%b exp 0/0", v, irq);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        $display("test_reset done: %0d compared", n_cmp);
    endtask

    task automatic test_autoreload();
        logic [WIDTH-1:0] v;
        wr(4'd0, 32'hFFFF_FFFC);
        wr(4'd1, 32'hFFFF_FFFC);
        wr(4'd3, 32'd0);
        wr(4'd2, 32'h3);
        for (int k = 1; k <= 3; k++) begin
            step();
            rd(4'd1, v);
            n_cmp++;
            if (v !== 32'hFFFF_FFFC + 32'(k) || ovf !== 3'b000) begin
                n_err++;
                $display("FAIL ar_count%0d got th=%h ovf=%b exp %h/000", k, v, ovf, 32'hFFFF_FFFC + 32'(k));
            end
        end
        step();
        rd(4'd1, v);
        n_cmp++;
        if (v !== 32'hFFFF_FFFC || ovf !== 3'b001 || irq !== 1'b0) begin
            n_err++;
            $display("FAIL ar_reload got th=%h ovf=%b irq=%b exp fffffffc/001/0", v, ovf, irq);
        end
        rd(4'd2, v);
        n_cmp++;
        if (v !== 32'h7) begin
            n_err++;
            $display("FAIL ar_stat got con=%h exp 7", v);
        end
        step();
        n_cmp++;
        if (ovf !== 3'b000 || irq !== 1'b1) begin
            n_err++;
            $display("FAIL ar_irq got ovf=%b irq=%b exp 000/1", ovf, irq);
        end
        wr(4'd2, 32'h7);
        step();
        rd(4'd2, v);
        n_cmp++;
        if (v !== 32'h3 || irq !== 1'b0) begin
            n_err++;
            $display("FAIL ar_w1c got con=%h irq=%b exp 3/0", v, irq);
        end
        step();
        wr(4'd2, 32'h3);
        rd(4'd2, v);
        n_cmp++;
        if (v !== 32'h7) begin
            n_err++;
            $display("FAIL ar_w0_keeps got con=%h exp 7", v);
        end
        step();
        step();
        wr(4'd2, 32'h7);
        rd(4'd2, v);
        n_cmp++;
        if (v !== 32'h7 || ovf !== 3'b001) begin
            n_err++;
            $display("FAIL col_w1c got con=%h ovf=%b exp 7/001", v, ovf);
        end
        repeat (3) step();
        wr(4'd0, 32'h55);
        rd(4'd1, v);
        n_cmp++;
        if (v !== 32'hFFFF_FFFC) begin
            n_err++;
            $display("FAIL col_tl_reload got th=%h exp fffffffc", v);
        end
        rd(4'd0, v);
        n_cmp++;
        if (v !== 32'h55) begin
            n_err++;
            $display("FAIL col_tl_new got tl=%h exp 55", v);
        end
        wr(4'd2, 32'h7);
        step();
        step();
        wr(4'd1, 32'h100);
        rd(4'd1, v);
        n_cmp++;
        if (v !== 32'h100 || ovf !== 3'b000) begin
            n_err++;
            $display("FAIL col_th_write got th=%h ovf=%b exp 100/000", v, ovf);
        end
        rd(4'd2, v);
        n_cmp++;
        if (v !== 32'h3) begin
            n_err++;
            $display("FAIL col_th_stat got con=%h exp 3", v);
        end
        wr(4'd2, 32'h4);
        $display("test_autoreload done: %0d compared", n_cmp);
    endtask

    task automatic test_prescale();
        logic [WIDTH-1:0] v;
        wr(4'd7, 32'd3);
        wr(4'd5, 32'd0);
        wr(4'd6, 32'h1);
        repeat (39) step();
        rd(4'd5, v);
        n_cmp++;
        if (v !== 32'd9) begin
            n_err++;
            $display("FAIL psc_39 got th=%0d exp 9", v);
        end
        step();
        rd(4'd5, v);
        n_cmp++;
        if (v !== 32'd10) begin
            n_err++;
            $display("FAIL psc_40 got th=%0d exp 10", v);
        end
        rd(4'd7, v);
        n_cmp++;
        if (v !== 32'd3) begin
            n_err++;
            $display("FAIL psc_read got psc=%h exp 3", v);
        end
        wr(4'd6, 32'h0);
        $display("test_prescale done: %0d compared", n_cmp);
    endtask

    task automatic test_oneshot();
        logic [WIDTH-1:0] v;
        wr(4'd0, 32'd0);
        wr(4'd1, 32'hFFFF_FFFE);
        wr(4'd2, 32'h9);
        step();
        rd(4'd1, v);
        n_cmp++;
        if (v !== 32'hFFFF_FFFF) begin
            n_err++;
            $display("FAIL os_tick1 got th=%h exp ffffffff", v);
        end
        step();
        rd(4'd1, v);
        n_cmp++;
        if (v !== 32'd0 || ovf !== 3'b001) begin
            n_err++;
            $display("FAIL os_ovf got th=%h ovf=%b exp 0/001", v, ovf);
        end
        rd(4'd2, v);
        n_cmp++;
        if (v !== 32'hC) begin
            n_err++;
            $display("FAIL os_con got con=%h exp c", v);
        end
        repeat (3) step();
        rd(4'd1, v);
        n_cmp++;
        if (v !== 32'd0 || irq !== 1'b0) begin
            n_err++;
            $display("FAIL os_hold got th=%h irq=%b exp 0/0", v, irq);
        end
        wr(4'd1, 32'hFFFF_FFFE);
        wr(4'd2, 32'h9);
        step();
        wr(4'd2, 32'h9);
        rd(4'd2, v);
        n_cmp++;
        if (v !== 32'hD) begin
            n_err++;
            $display("FAIL col_en_write got con=%h exp d", v);
        end
        wr(4'd2, 32'h4);
        $display("test_oneshot done: %0d compared", n_cmp);
    endtask

    task automatic test_independent();
        logic [WIDTH-1:0] v;
        wr(4'd1, 32'hFFFF_FFFD);
        wr(4'd0, 32'd0);
        wr(4'd3, 32'd0);
        wr(4'd4, 32'd0);
        wr(4'd5, 32'hFFFF_FFFF);
        wr(4'd7, 32'd1);
        wr(4'd6, 32'h3);
        wr(4'd2, 32'h3);
        step();
        rd(4'd1, v);
        n_cmp++;
        if (ovf !== 3'b010 || v !== 32'hFFFF_FFFE) begin
            n_err++;
            $display("FAIL ind_ch1_ovf got ovf=%b th0=%h exp 010/fffffffe", ovf, v);
        end
        step();
        rd(4'd2, v);
        n_cmp++;
        if (ovf !== 3'b000 || irq !== 1'b1 || v !== 32'h3) begin
            n_err++;
            $display("FAIL ind_irq1 got ovf=%b irq=%b con0=%h exp 000/1/3", ovf, irq, v);
        end
        step();
        n_cmp++;
        if (ovf !== 3'b001) begin
            n_err++;
            $display("FAIL ind_ch0_ovf got ovf=%b exp 001", ovf);
        end
        wr(4'd6, 32'h6);
        step();
        rd(4'd6, v);
        n_cmp++;
        if (irq !== 1'b1 || v !== 32'h2) begin
            n_err++;
            $display("FAIL ind_or got irq=%b con1=%h exp 1/2", irq, v);
        end
        wr(4'd2, 32'h6);
        step();
        n_cmp++;
        if (irq !== 1'b0) begin
            n_err++;
            $display("FAIL ind_clear got irq=%b exp 0", irq);
        end
        $display("test_independent done: %0d compared", n_cmp);
    endtask

    task automatic test_decode();
        logic [WIDTH-1:0] v;
        wr(4'd8, 32'hA5A5_A5A5);
        rd(4'd8, v);
        n_cmp++;
        if (v !== 32'hA5A5_A5A5) begin
            n_err++;
            $display("FAIL dec_ch2_tl got %h exp a5a5a5a5", v);
        end
        wr(4'd14, 32'hF);
        wr(4'd12, 32'h1234);
        rd(4'd14, v);
        n_cmp++;
        if (v !== 32'd0) begin
            n_err++;
            $display("FAIL dec_ch3_con got %h exp 0", v);
        end
        rd(4'd12, v);
        n_cmp++;
        if (v !== 32'd0) begin
            n_err++;
            $display("FAIL dec_ch3_tl got %h exp 0", v);
        end
        rd(4'd2, v);
        n_cmp++;
        if (v !== 32'h2) begin
            n_err++;
            $display("FAIL dec_ch0_intact got con=%h exp 2", v);
        end
        $display("test_decode done: %0d compared", n_cmp);
    endtask

    initial begin
        rst_n = 1'b0;
        wr_en = 1'b0;
        addr  = '0;
        wdata = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        test_reset();
        test_autoreload();
        test_prescale();
        test_oneshot();
        test_independent();
        test_decode();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
